// File: rtl/reg_bank_mp.sv
// rtl/reg_bank_mp.sv - multi-port register bank with bypassed registered reads, debug port and clear sweep
module reg_bank_mp #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clr_req_i,
    output logic                       busy_o,
    input  logic                       we_i,
    input  logic [ADDR_W-1:0]          waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic                       wr_ready_o,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    input  logic [ADDR_W-1:0]          dbg_addr_i,
    input  logic                       dbg_en_i,
    output logic [DATA_W-1:0]          dbg_data_o
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         ptr_q, ptr_d;
    logic [DATA_W-1:0]         mem_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0]  rd_data_q, rd_data_d;
    logic                      wr_commit;
    logic                      sweep_last;

    function automatic logic is_r0(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    assign sweep_last = (ptr_q == ADDR_W'(DEPTH-1));

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_CLEAR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clr_req_i)  state_d = S_CLEAR;
            S_CLEAR: if (sweep_last) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q == S_CLEAR);
        wr_ready_o = (state_q == S_IDLE);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_CLEAR)  ptr_d = ptr_q + ADDR_W'(1);
        else if (clr_req_i)      ptr_d = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // Writes to a hardwired-zero entry are acknowledged but never committed or bypassed.
    assign wr_commit = we_i && wr_ready_o && !is_r0(waddr_i);

    always_ff @(posedge clock) begin
        if (reset) begin
            if (busy_o)         mem_q[ptr_q]   <= '0;
            else if (wr_commit) mem_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        if (busy_o || is_r0(a))           return '0;
        if (wr_commit && (waddr_i == a))  return wdata_i;
        return mem_q[a];
    endfunction

    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data_d[k*DATA_W +: DATA_W] = read_port(rd_addr_i[k*ADDR_W +: ADDR_W]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data_o  = rd_data_q;
    assign dbg_data_o = (dbg_en_i && !busy_o && !is_r0(dbg_addr_i)) ? mem_q[dbg_addr_i] : '0;

endmodule

// File: doc/reg_bank_mp.md
Name:
reg_bank_mp

Overview:
- Parametrised successor to the 16x16 CPU register bank.
- Block contents:
  - 2**ADDR_W x DATA_W register array.
  - NUM_RD registered read ports with write-to-read bypass.
  - One write port with a ready handshake.
  - A combinational debug/display read port.
  - A sweep FSM that zeroes the whole array, one entry per cycle, after reset or on request.
- Sits between the control FSM/datapath and the display/debug logic.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_R0, 0, when 1 entry 0 is hardwired to zero: writes are dropped and reads return 0.

Ports:
- clock  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-low.
- clr_req  in  1  one-cycle pulse; starts a clear sweep when the FSM is IDLE.
- busy  out  1  1 while the sweep is running.
- we  in  1  write request.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wr_ready  out  1  write accepted this cycle (= !busy).
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data.
- dbg_addr  in  ADDR_W  debug/display address.
- dbg_en  in  1  debug enable.
- dbg_data  out  DATA_W  combinational debug value.

Behaviour:
- Reset (reset==0 at posedge):
  - FSM -> CLEAR, sweep pointer -> 0, rd_data -> 0.
  - Write requests in that cycle are ignored.
  - busy is 1 from the first cycle after reset deasserts.
- FSM has two states: IDLE and CLEAR.
  - IDLE -> CLEAR: on clr_req==1. Sweep pointer -> 0.
  - CLEAR, each cycle: array[ptr] <= 0, ptr <= ptr+1.
  - CLEAR -> IDLE: on the cycle that clears entry DEPTH-1.
  - A sweep therefore takes exactly DEPTH cycles; busy=1 for exactly those DEPTH cycles.
  - clr_req during CLEAR is ignored; it does not restart the sweep.
  - Reset during CLEAR restarts the sweep at ptr 0.
- Write port:
  - A write commits at posedge when we && wr_ready.
  - Writes are dropped, not queued, when busy=1.
  - With ZERO_R0=1 a write to waddr 0 is accepted (wr_ready=1) but discarded.
- Read ports:
  - Latency 1 cycle. rd_data[k] at cycle n+1 reflects rd_addr[k] sampled at posedge n.
  - Bypass: if an accepted write hits the same address in cycle n, rd_data[k] = wdata, not the old contents.
  - Several ports reading the same address all get the same value.
  - During busy, every port returns 0, including the cycle that follows the final sweep write.
  - With ZERO_R0=1, address 0 always reads 0 and is never bypassed.
- Debug port:
  - dbg_data = array[dbg_addr] when dbg_en==1 and busy==0; otherwise 0.
  - Purely combinational; no bypass, so it reflects committed contents only.
- Widths: no arithmetic. All addresses are in range by construction (DEPTH = 2**ADDR_W); the sweep pointer wraps naturally and is never compared past DEPTH-1.
- Simultaneous events:
  - clr_req and we in the same IDLE cycle: the write commits (wr_ready was 1) and the sweep starts next cycle, so the written value is later cleared.
  - reset==0 overrides clr_req and we.

Test Plan:
- Default params; reset low 1 cycle then high -> busy=1 for exactly 16 cycles, wr_ready=0 throughout, dbg_data=0. Then writing 0xBEEF to r5 gives rd_data port0 = 0xBEEF one cycle after rd_addr=5.
- Bypass: same cycle we=1, waddr=3, wdata=0x1234, rd_addr0=3, rd_addr1=3, old r3=0x0001 -> next cycle both ports read 0x1234; dbg_data(3) = 0x0001 before that edge and 0x1234 after it.
- Dropped write: clr_req pulse, then we=1, waddr=2, wdata=0xAAAA on sweep cycle 4 -> wr_ready=0; after busy falls r2 reads 0x0000.
- Mid-sweep reset: reset low at sweep cycle 7 -> sweep restarts, busy high for 16 cycles counted from reset release; all 16 entries read 0 afterwards.
- ZERO_R0=1: write 0xFFFF to r0 -> wr_ready=1, rd_data for r0 = 0, dbg_data(0) = 0; a write to r1 of 0xFFFF reads 0xFFFF.
- NUM_RD=4, DATA_W=32, ADDR_W=5: write distinct values to r0/r9/r17/r31, read all four ports simultaneously -> correct per-port values; full sweep lasts 32 cycles.
